bundle_ctrl: RTL and testbench
==============================

BUNDLE_CTRL -- requirements
Module: bundle_ctrl

Interface
REQ-001 SHALL have parameter D, default 32: hypervector width, one lane per external bundling counter.
REQ-002 SHALL have parameter NW, default 16: width of the item count.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begins a bundle operation; sampled only in IDLE.
REQ-006 SHALL have port num_items, input, NW: number of vectors to bundle; latched when start is accepted.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, D): the vector stream.
REQ-009 SHALL have ports cnt_bit (output, D), cnt_en (output, 1) and cnt_clr (output, 1): the per-lane bit, accumulate enable and synchronous clear for the counter array.
REQ-010 SHALL have port sign_in, input, D: sign bits from the counter array; 1 = negative count.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, D): the bundled result.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the result handshake completes.

Function
REQ-013 SHALL implement a state machine with states IDLE, CLR, ACCUM, SETTLE and OUT.
REQ-014 IDLE with start=1 SHALL latch num_items, then go to CLR; start outside IDLE SHALL be ignored.
REQ-015 CLR SHALL assert cnt_clr=1 for exactly one cycle, then go to ACCUM, or to SETTLE if the latched num_items=0.
REQ-016 ACCUM SHALL drive in_ready=1 and cnt_en=in_valid, with cnt_bit=in_data combinationally.
REQ-017 Each ACCUM handshake (in_valid & in_ready) SHALL increment the item counter; the handshake at index num_items-1 SHALL move to SETTLE.
REQ-018 SETTLE SHALL last one cycle, with no cnt_en and in_ready=0, so that the last counter update is visible; at its end sign_in SHALL be registered into out_data.
REQ-019 OUT SHALL hold out_valid=1 with out_data stable until out_ready=1, then pulse done=1 for one cycle and return to IDLE.
REQ-020 For the last input handshake in cycle t, out_valid SHALL first be high in cycle t+2.
REQ-021 cnt_en SHALL never be high while cnt_clr is high, and never outside ACCUM.
REQ-022 in_valid gaps SHALL stall ACCUM with no cnt_en pulse and no count change.
REQ-023 out_data SHALL reflect the counter convention: tie or majority-0 lanes read 0, majority-1 lanes read 1; num_items=0 SHALL give all zeros.
REQ-024 The item counter SHALL be NW bits and SHALL never wrap within an operation; the maximum is 2^NW-1 items.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, item counter 0, out_data 0, and busy, in_ready, cnt_en, cnt_clr, out_valid and done all 0.
REQ-026 Reset mid-operation SHALL discard the operation; the counter array is not cleared by reset, and the next start's CLR state clears it.

Configuration
REQ-027 With BUNDLE_CTRL_ABORT_EN defined, the block SHALL add an input port abort (1 bit).
REQ-028 With abort=1 in any non-IDLE state, the block SHALL go to CLR, pulse cnt_clr once, then return to IDLE with no out_valid and no done.
REQ-029 With BUNDLE_CTRL_ABORT_EN undefined, the abort port and its logic SHALL be absent; behaviour SHALL be exactly as in REQ-013 to REQ-026.

Verification (D=8, behavioural counter model attached)
REQ-030 num_items=3, vectors 0x0F, 0x0F, 0xF0 back-to-back -> one cnt_clr, three cnt_en pulses, out_data=0x0F two cycles after the last handshake, then done.
REQ-031 num_items=2, vectors 0xFF, 0x00 (tie) -> out_data=0x00.
REQ-032 num_items=4 with in_valid low on alternate cycles, and out_ready low for 5 cycles -> exactly 4 cnt_en pulses, out_data stable while stalled, busy high until done.
REQ-033 num_items=0 -> cnt_clr once, no cnt_en, out_data=0x00, done pulsed.
REQ-034 rst_n low after 1 of 3 items -> all outputs 0 at once; a new start with num_items=1 and vector 0xAA -> cnt_clr first, then out_data=0xAA.
REQ-035 With BUNDLE_CTRL_ABORT_EN: abort in ACCUM after 2 items -> one cnt_clr, IDLE, no out_valid and no done; a restart gives a correct result.

Source files
------------

// File: rtl/bundle_ctrl.sv
// bundle_ctrl: sequences an external per-lane bundling counter array and reads back its sign bits.
// Defining BUNDLE_CTRL_ABORT_EN adds an abort input that cancels a running operation.
module bundle_ctrl #(
  parameter int D  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] num_items,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_data,
  output logic [D-1:0]  cnt_bit,
  output logic          cnt_en,
  output logic          cnt_clr,
  input  logic [D-1:0]  sign_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_data,
`ifdef BUNDLE_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          done
);

  typedef enum logic [2:0] {IDLE, CLR, ACCUM, SETTLE, OUT} state_t;

  state_t        state;
  logic [NW-1:0] n_lat;
  logic [NW-1:0] item_cnt;
  logic          acc_q;
  logic          hs;
`ifdef BUNDLE_CTRL_ABORT_EN
  logic          abort_pend;
`endif

  // An abort in the same cycle as a beat refuses the beat so the counters stay untouched.
`ifdef BUNDLE_CTRL_ABORT_EN
  assign in_ready = acc_q & ~abort;
`else
  assign in_ready = acc_q;
`endif
  assign hs      = in_ready & in_valid;
  assign cnt_en  = hs;
  assign cnt_bit = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_lat     <= '0;
      item_cnt  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      acc_q     <= 1'b0;
      cnt_clr   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef BUNDLE_CTRL_ABORT_EN
      abort_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BUNDLE_CTRL_ABORT_EN
      // Abort reuses CLR so the counter array is left clean for the next operation.
      if (abort && state != IDLE) begin
        state      <= CLR;
        cnt_clr    <= 1'b1;
        busy       <= 1'b1;
        acc_q      <= 1'b0;
        out_valid  <= 1'b0;
        item_cnt   <= '0;
        abort_pend <= 1'b1;
      end else
`endif
      case (state)
        IDLE: begin
          if (start) begin
            n_lat    <= num_items;
            item_cnt <= '0;
            cnt_clr  <= 1'b1;
            busy     <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          cnt_clr <= 1'b0;
`ifdef BUNDLE_CTRL_ABORT_EN
          if (abort_pend) begin
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else
`endif
          if (n_lat == '0) begin
            state <= SETTLE;
          end else begin
            acc_q <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (hs) begin
            item_cnt <= item_cnt + 1'b1;
            if (item_cnt == n_lat - 1'b1) begin
              acc_q <= 1'b0;
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // The last counter update landed on the previous edge, so sign_in is final here.
          out_data  <= (n_lat == '0) ? '0 : sign_in;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_ctrl.sv
// Self-checking bench for bundle_ctrl with an attached behavioural counter array and an
// operation-level majority model; exercises the abort path when BUNDLE_CTRL_ABORT_EN is defined.
module tb_bundle_ctrl;
  localparam int D  = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] num_items = '0;
  logic          in_valid = 1'b0;
  logic [D-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          abort = 1'b0;
  logic [D-1:0]  sign_in;
  logic          busy, in_ready, cnt_en, cnt_clr, out_valid, done;
  logic [D-1:0]  cnt_bit, out_data;

  int checks = 0;
  int errors = 0;

  bundle_ctrl #(.D(D), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_items(num_items), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cnt_bit(cnt_bit), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BUNDLE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // External counter array: a 1 bit pulls the lane negative, so majority-1 reads sign=1.
  int acc [D];
  always @(posedge clk) begin
    if (cnt_clr) begin
      for (int b = 0; b < D; b++) acc[b] <= 0;
    end else if (cnt_en) begin
      for (int b = 0; b < D; b++) acc[b] <= acc[b] + (cnt_bit[b] ? -1 : 1);
    end
  end
  always_comb begin
    sign_in = '0;
    for (int b = 0; b < D; b++) sign_in[b] = (acc[b] < 0);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Operation-level model state, owned by the monitor.
  bit           m_act, m_pend, m_fin;
  int           m_n, m_hs, m_clr_cyc, m_last_hs, m_cyc, m_ab;
  int           n_en, n_clr;
  logic [D-1:0] m_items [$];

  function automatic logic [D-1:0] majority();
    logic [D-1:0] r;
    r = '0;
    for (int b = 0; b < D; b++) begin
      int ones;
      ones = 0;
      foreach (m_items[k]) ones += int'(m_items[k][b]);
      r[b] = (2 * ones > m_items.size());
    end
    return r;
  endfunction

  always @(negedge clk) begin : mon
    bit hs, idle_now, e_clr, e_busy, e_ir, e_ov;
    int due;
    m_cyc++;
    if (!rst_n) begin
      m_act = 0; m_pend = 0; m_fin = 0; m_ab = 0; m_hs = 0;
      m_items.delete();
    end else begin
      chk("done", int'(done), int'(m_fin));
      m_fin = 0;
      if (m_pend) begin
        m_pend = 0; m_act = 1; m_clr_cyc = m_cyc; m_hs = 0;
        m_items.delete();
      end
      hs = in_valid && in_ready;
      n_en  += int'(cnt_en);
      n_clr += int'(cnt_clr);
      e_clr  = (m_act && m_clr_cyc == m_cyc) || m_ab == 1;
      e_busy = m_act || m_ab == 1;
      e_ir   = m_act && m_n > 0 && m_cyc > m_clr_cyc && m_hs < m_n && !abort;
      due    = (m_n > 0) ? m_last_hs + 2 : m_clr_cyc + 2;
      e_ov   = m_act && m_hs == m_n && m_cyc >= due;
      chk("cnt_en_vs_hs", int'(cnt_en), int'(hs));
      chk("en_clr_excl", int'(cnt_en & cnt_clr), 0);
      chk("cnt_clr", int'(cnt_clr), int'(e_clr));
      chk("busy", int'(busy), int'(e_busy));
      chk("in_ready", int'(in_ready), int'(e_ir));
      chk("out_valid", int'(out_valid), int'(e_ov));
      if (out_valid && e_ov) chk("out_data", int'(out_data), int'(majority()));
      idle_now = !m_act && m_ab == 0;
      if (m_ab == 1) m_ab = 0;
      if (abort && m_act) begin
        m_ab = 1; m_act = 0;
        m_items.delete();
      end else if (m_act) begin
        if (hs) begin
          m_items.push_back(in_data);
          m_hs++;
          m_last_hs = m_cyc;
        end
        if (e_ov && out_ready) begin
          m_fin = 1; m_act = 0;
        end
      end
      if (idle_now && start) begin
        m_pend = 1;
        m_n = int'(num_items);
      end
    end
  end

  logic [D-1:0] vq [$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_in_ready"}, int'(in_ready), 0);
    chk({nm, "_cnt_en"}, int'(cnt_en), 0);
    chk({nm, "_cnt_clr"}, int'(cnt_clr), 0);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_out_data"}, int'(out_data), 0);
  endtask

  // gap: 0 back-to-back, 100 alternate cycles, otherwise percent of idle beats.
  task automatic do_op(input int n, input int gap, input int stall, input bit use_list,
                       output logic [D-1:0] res);
    int i, g;
    bit v, alt, seen;
    res = '0;
    wait_idle();
    num_items = NW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    i = 0; g = 0; alt = 1;
    while (i < n && g < 500) begin
      g++;
      if (gap == 0) v = 1;
      else if (gap == 100) begin v = alt; alt = !alt; end
      else v = ($urandom_range(99) >= gap);
      in_valid  = v;
      in_data   = (v && use_list) ? vq[i] : D'($urandom);
      start     = ($urandom_range(3) == 0);
      num_items = NW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (i < n) chk("feed_timeout", i, n);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; res = out_data; end
    end
    chk("out_timeout", int'(seen), 1);
    @(posedge clk); #1;
    repeat (stall) step();
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid && out_ready;
      @(posedge clk); #1;
    end
    chk("out_hs", int'(seen), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [D-1:0] r;
    int e0, c0, got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    vq = '{8'h0F, 8'h0F, 8'hF0};
    e0 = n_en; c0 = n_clr;
    do_op(3, 0, 0, 1, r);
    chk("b2b_data", int'(r), 8'h0F);
    chk("b2b_en", n_en - e0, 3);
    chk("b2b_clr", n_clr - c0, 1);

    vq = '{8'hFF, 8'h00};
    do_op(2, 0, 1, 1, r);
    chk("tie_data", int'(r), 8'h00);

    vq = '{8'h3C, 8'h3C, 8'h3C, 8'h00};
    e0 = n_en;
    do_op(4, 100, 5, 1, r);
    chk("gap_data", int'(r), 8'h3C);
    chk("gap_en", n_en - e0, 4);

    e0 = n_en; c0 = n_clr;
    do_op(0, 0, 0, 0, r);
    chk("zero_data", int'(r), 8'h00);
    chk("zero_en", n_en - e0, 0);
    chk("zero_clr", n_clr - c0, 1);

    vq.delete();
    for (int k = 0; k < 15; k++) vq.push_back(k < 8 ? 8'hC3 : 8'h3C);
    e0 = n_en;
    do_op(15, 30, 2, 1, r);
    chk("max_data", int'(r), 8'hC3);
    chk("max_en", n_en - e0, 15);

    wait_idle();
    num_items = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    got = 0;
    for (int g = 0; g < 20 && got == 0; g++) begin
      @(negedge clk);
      if (in_valid && in_ready) got = 1;
      @(posedge clk); #1;
    end
    chk("rst_first_hs", got, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_rst("midrst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vq = '{8'hAA};
    c0 = n_clr;
    do_op(1, 0, 0, 1, r);
    chk("post_rst_data", int'(r), 8'hAA);
    chk("post_rst_clr", n_clr - c0, 1);

`ifdef BUNDLE_CTRL_ABORT_EN
    wait_idle();
    e0 = n_en; c0 = n_clr;
    num_items = 4'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h0F;
    got = 0;
    for (int g = 0; g < 20 && got < 2; g++) begin
      @(negedge clk);
      if (in_valid && in_ready) got++;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    chk("abort_clr", n_clr - c0, 2);
    chk("abort_en", n_en - e0, 2);
    chk("abort_idle", int'(busy), 0);
    vq = '{8'hF0, 8'hF0, 8'h0F};
    do_op(3, 0, 0, 1, r);
    chk("abort_restart_data", int'(r), 8'hF0);
`endif

    for (int op = 0; op < 30; op++) begin
      int sel, gp;
      sel = $urandom_range(2);
      gp = (sel == 0) ? 0 : (sel == 1) ? 35 : 100;
      do_op($urandom_range(15), gp, $urandom_range(4), 0, r);
    end

    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
